// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifu_pkg;

    // Fetch sequencer states: idle, waiting on memory, holding a buffered
    // instruction, and draining a response made stale by a redirect.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2,
        DROP = 2'd3
    } ifu_state_e;

    // Next-PC source selection.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam int          PC_STEP          = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ifu_pc_fetch_pc_next_sel.sv
// Combinational next-PC select: keep, step by one instruction, or take a
// word-aligned redirect target.
module pc_next_sel
    import ifu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  pc_sel_e             sel_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic [ADDR_W-1:0]   target_i,
    output logic [ADDR_W-1:0]   pc_next_o
);

    // Redirect targets have their two low bits cleared; increment wraps.
    always_comb begin
        pc_next_o = pc_i;
        unique case (sel_i)
            PC_INC:      pc_next_o = pc_i + ADDR_W'(PC_STEP);
            PC_REDIRECT: pc_next_o = target_i & ~ADDR_W'(3);
            default:     pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/ifu_pc_fetch.sv
// Instruction-fetch front end: owns the PC, keeps at most one fetch in
// flight, registers fetched instructions toward decode, applies redirects
// and drops stale responses.
// Optional macro IFU_PERF_CNT_EN adds fetch/flush performance counters.
module ifu_pc_fetch
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_flag_i,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    input  logic                hold_flag_i,
    output logic                imem_req_valid_o,
    input  logic                imem_req_ready_i,
    output logic [ADDR_W-1:0]   imem_req_addr_o,
    input  logic                imem_rsp_valid_i,
    input  logic [INST_W-1:0]   imem_rsp_data_i,
    output logic                inst_valid_o,
    output logic [INST_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_pc_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]         perf_fetch_cnt_o,
    output logic [63:0]         perf_flush_cnt_o
`endif
);

    localparam logic [INST_W-1:0] NOP = INST_W'(NOP_INST);

    ifu_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   buf_q, buf_d;
    logic                inst_valid_q, inst_valid_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    pc_sel_e             pc_sel;
    logic                load_event;
    logic [INST_W-1:0]   load_data;
    logic                req_valid;

    // Request is offered only from IDLE, never while held or redirecting;
    // it is also masked during reset because the FSM ignores acceptance then.
    assign req_valid        = (state_q == IDLE) & ~hold_flag_i & ~jump_flag_i & ~rst;
    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_q;

    pc_next_sel #(
        .ADDR_W    (ADDR_W)
    ) u_pc_next_sel (
        .sel_i     (pc_sel),
        .pc_i      (pc_q),
        .target_i  (jump_addr_i),
        .pc_next_o (pc_d)
    );

    // Sequencer next state, PC source and decode-load selection.
    always_comb begin
        state_d    = state_q;
        pc_sel     = PC_HOLD;
        buf_d      = buf_q;
        load_event = 1'b0;
        load_data  = buf_q;
        unique case (state_q)
            IDLE: begin
                if (jump_flag_i) begin
                    pc_sel = PC_REDIRECT;
                end else if (req_valid && imem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (jump_flag_i) begin
                    pc_sel  = PC_REDIRECT;
                    state_d = imem_rsp_valid_i ? IDLE : DROP;
                end else if (imem_rsp_valid_i && !hold_flag_i) begin
                    load_event = 1'b1;
                    load_data  = imem_rsp_data_i;
                    pc_sel     = PC_INC;
                    state_d    = IDLE;
                end else if (imem_rsp_valid_i) begin
                    buf_d   = imem_rsp_data_i;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (jump_flag_i) begin
                    pc_sel  = PC_REDIRECT;
                    state_d = IDLE;
                end else if (!hold_flag_i) begin
                    load_event = 1'b1;
                    load_data  = buf_q;
                    pc_sel     = PC_INC;
                    state_d    = IDLE;
                end
            end
            DROP: begin
                if (jump_flag_i) begin
                    pc_sel = PC_REDIRECT;
                end
                if (imem_rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode-side registers: redirect flushes, hold freezes, otherwise load or bubble.
    always_comb begin
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        if (jump_flag_i) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP;
        end else if (hold_flag_i) begin
            inst_valid_d = inst_valid_q;
        end else if (load_event) begin
            inst_valid_d = 1'b1;
            inst_d       = load_data;
            inst_pc_d    = pc_q;
        end else begin
            inst_valid_d = 1'b0;
        end
    end

    // State, PC, buffer and decode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            buf_q        <= NOP;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP;
            inst_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt_q;
    logic [63:0] flush_cnt_q;

    // Count delivered instructions and redirects that kill an in-flight fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 64'd0;
            flush_cnt_q <= 64'd0;
        end else begin
            if (load_event) begin
                fetch_cnt_q <= fetch_cnt_q + 64'd1;
            end
            if (jump_flag_i && (state_q != IDLE)) begin
                flush_cnt_q <= flush_cnt_q + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    // Without the counters the front end carries no extra state.
`endif

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Directed testbench for ifu_pc_fetch: stimulus pushes expected decode
// outputs into a scoreboard queue, a monitor pops them on consumption.
module tb_ifu_pc_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [63:0] jump_addr_i;
    logic        hold_flag_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt_o;
    logic [63:0] perf_flush_cnt_o;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    ifu_pc_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .jump_flag_i      (jump_flag_i),
        .jump_addr_i      (jump_addr_i),
        .hold_flag_i      (hold_flag_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of inputs: applied just after the rising edge, held until the next.
    task automatic applyStimulus(input logic r, input logic j, input logic [63:0] ja,
                                 input logic h, input logic rdy, input logic rv,
                                 input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst              = r;
        jump_flag_i      = j;
        jump_addr_i      = ja;
        hold_flag_i      = h;
        imem_req_ready_i = rdy;
        imem_rsp_valid_i = rv;
        imem_rsp_data_i  = rd;
        #1;
    endtask

    task automatic idleCycle(input logic h);
        applyStimulus(1'b0, 1'b0, 64'h0, h, 1'b0, 1'b0, 32'h0);
    endtask

    // Accept a request at pc, then return data one cycle later with no hold.
    task automatic doFetch(input logic [31:0] data, input logic [63:0] pc);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("fetch_req_valid", 64'(imem_req_valid_o), 64'd1);
        checkOutput("fetch_req_addr", imem_req_addr_o, pc);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, data);
        sb_q.push_back('{inst: data, pc: pc});
        checkOutput("wait_no_req", 64'(imem_req_valid_o), 64'd0);
    endtask

    // Monitor: decode consumes an instruction when valid and not held.
    always @(negedge clk) begin
        if (!rst && inst_valid_o && !hold_flag_i) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_valid", 64'(inst_valid_o), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("sb_inst", 64'(inst_o), 64'(e.inst));
                checkOutput("sb_pc", inst_pc_o, e.pc);
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = 64'h0; hold_flag_i = 1'b0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;

        // Reset
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_inst_valid", 64'(inst_valid_o), 64'd0);
        checkOutput("rst_inst", 64'(inst_o), 64'(NOP));
        checkOutput("rst_inst_pc", inst_pc_o, 64'h8000_0000);
        checkOutput("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
`ifdef IFU_PERF_CNT_EN
        checkOutput("rst_fetch_cnt", perf_fetch_cnt_o, 64'd0);
        checkOutput("rst_flush_cnt", perf_flush_cnt_o, 64'd0);
`endif

        // Back-to-back 1-cycle fetches
        $display("[TB] sequential fetch");
        doFetch(32'h0000_0093, 64'h8000_0000);
        doFetch(32'h0000_0113, 64'h8000_0004);
        idleCycle(1'b0);
        checkOutput("idle_req_addr", imem_req_addr_o, 64'h8000_0008);

        // Redirect in WAIT, stale response 3 cycles later
        $display("[TB] redirect with late response");
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("s2_req_addr", imem_req_addr_o, 64'h8000_0008);
        applyStimulus(1'b0, 1'b1, 64'h8000_1006, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("s2_jump_no_req", 64'(imem_req_valid_o), 64'd0);
        idleCycle(1'b0);
        checkOutput("s2_flush_valid", 64'(inst_valid_o), 64'd0);
        checkOutput("s2_flush_inst", 64'(inst_o), 64'(NOP));
        checkOutput("s2_drop_no_req", 64'(imem_req_valid_o), 64'd0);
        idleCycle(1'b0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        idleCycle(1'b0);
        checkOutput("s2_req_valid", 64'(imem_req_valid_o), 64'd1);
        checkOutput("s2_req_addr_target", imem_req_addr_o, 64'h8000_1004);
        checkOutput("s2_dropped_valid", 64'(inst_valid_o), 64'd0);

        // Redirect and response in the same WAIT cycle
        $display("[TB] redirect coincident with response");
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("s3_req_addr", imem_req_addr_o, 64'h8000_1004);
        applyStimulus(1'b0, 1'b1, 64'h8000_2000, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
        idleCycle(1'b0);
        checkOutput("s3_idle_req", 64'(imem_req_valid_o), 64'd1);
        checkOutput("s3_req_addr_target", imem_req_addr_o, 64'h8000_2000);
        checkOutput("s3_no_valid", 64'(inst_valid_o), 64'd0);

        // Hold across response arrival
        $display("[TB] hold during response");
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'h00A0_0513);
        for (int i = 0; i < 3; i++) begin
            idleCycle(1'b1);
            checkOutput("s4_hold_no_req", 64'(imem_req_valid_o), 64'd0);
            checkOutput("s4_hold_valid", 64'(inst_valid_o), 64'd0);
            checkOutput("s4_hold_inst", 64'(inst_o), 64'(NOP));
        end
        idleCycle(1'b0);
        sb_q.push_back('{inst: 32'h00A0_0513, pc: 64'h8000_2000});
        checkOutput("s4_full_no_req", 64'(imem_req_valid_o), 64'd0);
        idleCycle(1'b0);
        checkOutput("s4_release_valid", 64'(inst_valid_o), 64'd1);
        checkOutput("s4_release_inst", 64'(inst_o), 64'h00A0_0513);
        checkOutput("s4_pc_advanced", imem_req_addr_o, 64'h8000_2004);
        idleCycle(1'b0);
        checkOutput("s4_single_pulse", 64'(inst_valid_o), 64'd0);

        // Hold freezes a presented instruction
        $display("[TB] hold with valid output");
        doFetch(32'h0000_0233, 64'h8000_2004);
        idleCycle(1'b1);
        checkOutput("s4b_valid_held", 64'(inst_valid_o), 64'd1);
        checkOutput("s4b_inst_held", 64'(inst_o), 64'h0000_0233);
        idleCycle(1'b1);
        checkOutput("s4b_valid_still", 64'(inst_valid_o), 64'd1);
        checkOutput("s4b_pc_still", inst_pc_o, 64'h8000_2004);
        idleCycle(1'b0);

        // Memory not ready, then reset in WAIT
        $display("[TB] backpressure and reset mid-fetch");
        for (int i = 0; i < 5; i++) begin
            idleCycle(1'b0);
            checkOutput("s5_req_stable_v", 64'(imem_req_valid_o), 64'd1);
            checkOutput("s5_req_stable_a", imem_req_addr_o, 64'h8000_2008);
        end
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("s5_rst_req_masked", 64'(imem_req_valid_o), 64'd0);
        idleCycle(1'b0);
        checkOutput("s5_rst_valid", 64'(inst_valid_o), 64'd0);
        checkOutput("s5_rst_inst", 64'(inst_o), 64'(NOP));
        checkOutput("s5_rst_inst_pc", inst_pc_o, 64'h8000_0000);
        checkOutput("s5_rst_req_addr", imem_req_addr_o, 64'h8000_0000);
        checkOutput("s5_rst_req_valid", 64'(imem_req_valid_o), 64'd1);
`ifdef IFU_PERF_CNT_EN
        checkOutput("s5_rst_fetch_cnt", perf_fetch_cnt_o, 64'd0);
`endif
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0000);
        idleCycle(1'b0);
        checkOutput("s5_late_rsp_ignored", 64'(inst_valid_o), 64'd0);

        // Three fetches and one flush in WAIT
        $display("[TB] fetch/flush counting");
        doFetch(32'h0010_0093, 64'h8000_0000);
        doFetch(32'h0020_0113, 64'h8000_0004);
        doFetch(32'h0030_0193, 64'h8000_0008);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 64'h8000_0100, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 32'h0040_0213);
        idleCycle(1'b0);
        checkOutput("s6_req_addr", imem_req_addr_o, 64'h8000_0100);
        checkOutput("s6_no_valid", 64'(inst_valid_o), 64'd0);
`ifdef IFU_PERF_CNT_EN
        checkOutput("s6_fetch_cnt", perf_fetch_cnt_o, 64'd3);
        checkOutput("s6_flush_cnt", perf_flush_cnt_o, 64'd1);
`endif
        idleCycle(1'b0);

        checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_pc_fetch.md
Name: ifu_pc_fetch

Overview:
- Instruction-fetch front end: the consumer of the control unit's jump/hold outputs.
- Owns the program counter, issues one-outstanding-request fetches to instruction memory, and registers fetched instructions plus their PC toward decode.
- Applies redirects from execute and discards stale in-flight responses; holds decode outputs while stalled.

Parameters:
- ADDR_W, 64, PC and memory address width
- INST_W, 32, instruction width
- RESET_PC, 64'h8000_0000, PC value after reset

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- jump_flag_i  in  1  redirect request from control
- jump_addr_i  in  ADDR_W  redirect target
- hold_flag_i  in  1  pipeline hold from control
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  ADDR_W  fetch address
- imem_rsp_valid_i  in  1  response data valid; exactly one per accepted request, earliest the cycle after acceptance
- imem_rsp_data_i  in  INST_W  fetched instruction
- inst_valid_o  out  1  instruction to decode valid
- inst_o  out  INST_W  instruction to decode
- inst_pc_o  out  ADDR_W  PC of inst_o

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high.
- Reset values: pc_q=RESET_PC, state=IDLE, imem_req_valid_o=0, inst_valid_o=0, inst_o=NOP (32'h0000_0013), inst_pc_o=RESET_PC, buffer empty.
- Redirect alignment: target = {jump_addr_i[ADDR_W-1:2], 2'b00}.
- Request signals (combinational): imem_req_valid_o = (state==IDLE) & ~hold_flag_i & ~jump_flag_i; imem_req_addr_o = pc_q.
  - Withdrawing an unaccepted request on hold/jump is permitted.
- IDLE state:
  - jump: pc_q<=target; stay IDLE.
  - req valid & ready: -> WAIT.
- WAIT state:
  - jump with or without rsp_valid: pc_q<=target; -> IDLE if rsp_valid this cycle (response dropped), else -> DROP.
  - rsp_valid & ~hold: output regs load {1, data, pc_q}; pc_q<=pc_q+4; -> IDLE.
  - rsp_valid & hold: buffer<=data; pc_q unchanged; -> FULL.
- FULL state:
  - jump: buffer discarded; pc_q<=target; -> IDLE.
  - ~hold: output regs load {1, buffer, pc_q}; pc_q<=pc_q+4; -> IDLE.
  - No request issued while in FULL.
- DROP state:
  - rsp_valid: discard; -> IDLE.
  - Jump while in DROP: pc_q<=newest target; stay DROP unless rsp_valid that cycle.
- Output registers:
  - jump (any state): inst_valid_o<=0, inst_o<=NOP; inst_pc_o unchanged.
  - Else hold: all outputs keep value.
  - Else no load event: inst_valid_o<=0 (bubble), inst_o/inst_pc_o keep.
- Priority: rst > jump > hold > response.
- Latency: request-to-decode = memory latency + 1 cycle. Maximum throughput is one instruction per 2 cycles for 1-cycle memory.
- PC arithmetic: pc_q+4 wraps modulo 2^ADDR_W, with no overflow flag.
- Reset mid-fetch: the FSM returns to IDLE. A response arriving after reset is ignored, and the memory side must tolerate this.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt_o[63:0] and perf_flush_cnt_o[63:0], both reset to 0.
  - fetch_cnt increments on each output load with valid=1.
  - flush_cnt increments on each cycle jump_flag_i=1 while state is WAIT, FULL or DROP.
  - Both wrap.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package ifu_pkg:
  - state enum {IDLE, WAIT, FULL, DROP}
  - NOP_INST constant 32'h0000_0013
  - PC_STEP constant 4
  - default RESET_PC
- One natural sub-module: pc_next_sel, combinational next-PC select among hold/increment/redirect with alignment masking.

Test Plan:
- Reset then 1-cycle memory with ready=1 returning 0x00000093, 0x00000113 -> inst_valid_o pulses with inst_pc_o=0x80000000 then 0x80000004; req addrs 0x80000000, 0x80000004.
- Jump to 0x80001006 issued in WAIT, response 0xDEADBEEF arrives 3 cycles later -> response dropped, inst_valid_o=0/inst_o=NOP after jump, next req addr 0x80001004.
- Jump and rsp_valid in same WAIT cycle -> no valid output, state IDLE next cycle, next req addr = target.
- hold_flag_i=1 for 4 cycles as response 0x00A00513 arrives -> outputs frozen, no new request; on hold release, inst_o=0x00A00513 valid for 1 cycle, pc_q advanced by 4.
- imem_req_ready_i=0 for 5 cycles -> req_valid and addr stable; rst asserted during WAIT -> all outputs at reset values the next cycle.
- With IFU_PERF_CNT_EN: 3 fetches and 1 flush in WAIT -> perf_fetch_cnt_o=3, perf_flush_cnt_o=1.
